// File: rtl/fpadd_sched_pkg.sv
// rtl/fpadd_sched_pkg.sv - shared types and constants for the float add scheduler
package fpadd_sched_pkg;

  localparam int FP_W  = 32;
  localparam int CNT_W = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand pair plus the id of the requester that supplied it
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            id;
  } op_t;

endpackage

// File: rtl/fpadd_core.sv
// rtl/fpadd_core.sv - combinational single-precision adder, round-to-nearest-even
module fpadd_core
  import fpadd_sched_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic        sl, ss;
  logic [7:0]  ea, eb, el, es;
  logic [23:0] ma, mb, ml, ms;
  logic        swap;
  logic [7:0]  d;
  logic [4:0]  sh;
  logic [47:0] s_ext;
  logic [26:0] l_al, s_al;
  logic [27:0] raw;
  logic        eff_sub;

  logic [26:0] m_pre;
  logic [8:0]  e_pre;
  logic [4:0]  lz;
  logic [4:0]  lsh;
  logic [26:0] m_norm;
  logic [8:0]  e_norm;
  logic        rnd_up;
  logic [24:0] m_rnd;
  logic [7:0]  e_fin;
  logic [22:0] f_fin;
  logic        s_fin;

  // Unpack, order by magnitude and align the smaller operand with guard/round/sticky bits
  always_comb begin
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {|a[30:23], a[22:0]};
    mb = {|b[30:23], b[22:0]};

    swap = (b[30:0] > a[30:0]);
    sl   = swap ? b[31] : a[31];
    ss   = swap ? a[31] : b[31];
    el   = swap ? eb : ea;
    es   = swap ? ea : eb;
    ml   = swap ? mb : ma;
    ms   = swap ? ma : mb;

    // A shift of 27 already pushes the whole mantissa below the round bit
    d     = el - es;
    sh    = (d > 8'd27) ? 5'd27 : d[4:0];
    s_ext = {ms, 24'b0} >> sh;
    s_al  = {s_ext[47:22], |s_ext[21:0]};
    l_al  = {ml, 3'b000};

    eff_sub = (sl != ss);
    if (eff_sub) begin
      raw = {1'b0, l_al} - {1'b0, s_al};
    end else begin
      raw = {1'b0, l_al} + {1'b0, s_al};
    end
  end

  // Normalise: fold a carry-out right, otherwise shift left but never below exponent 1
  always_comb begin
    if (raw[27]) begin
      m_pre = {raw[27:2], raw[1] | raw[0]};
      e_pre = {1'b0, el} + 9'd1;
    end else begin
      m_pre = raw[26:0];
      e_pre = {1'b0, el};
    end

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (m_pre[i]) lz = 5'(26 - i);
    end

    if ({4'b0, lz} >= e_pre) begin
      lsh = 5'(e_pre - 9'd1);
    end else begin
      lsh = lz;
    end

    m_norm = m_pre << lsh;
    e_norm = e_pre - {4'b0, lsh};
  end

  // Round to nearest, ties to even, then pack; a denormal that rounds up becomes normal
  always_comb begin
    rnd_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
    m_rnd  = {1'b0, m_norm[26:3]} + {24'b0, rnd_up};

    if (m_rnd[24]) begin
      e_fin = 8'(e_norm + 9'd1);
      f_fin = m_rnd[23:1];
    end else if (m_rnd[23]) begin
      e_fin = e_norm[7:0];
      f_fin = m_rnd[22:0];
    end else begin
      e_fin = 8'd0;
      f_fin = m_rnd[22:0];
    end

    // Exact cancellation yields +0; like-signed zeros keep their sign
    s_fin = (eff_sub && (raw == '0)) ? 1'b0 : sl;
    sum   = {s_fin, e_fin, f_fin};
  end

endmodule

// File: rtl/fpadd_sched.sv
// rtl/fpadd_sched.sv - two-requester arbiter and FSM around a float adder
module fpadd_sched
  import fpadd_sched_pkg::*;
#(
  parameter int RR_EN = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [FP_W-1:0]  req0_a,
  input  logic [FP_W-1:0]  req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [FP_W-1:0]  req1_a,
  input  logic [FP_W-1:0]  req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [FP_W-1:0]  rsp_sum,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  state_t           state_q, state_d;
  op_t              op_q;
  logic             last_q;
  logic             grant_id;
  logic             any_valid;
  logic             accept;
  logic [FP_W-1:0]  core_sum;
  logic [FP_W-1:0]  sum_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt_q;

  // Pick a winner: alternate on a tie in round-robin mode, else requester 0 wins ties
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = REQ0;
    if (req0_valid && req1_valid) begin
      grant_id = (RR_EN != 0) ? ~last_q : REQ0;
    end else if (req1_valid) begin
      grant_id = REQ1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; ready is held off while reset is asserted
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid && rst_n) begin
          accept     = 1'b1;
          req0_ready = (grant_id == REQ0);
          req1_ready = (grant_id == REQ1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted operands and their owner on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (accept) begin
      op_q.a  <= (grant_id == REQ1) ? req1_a : req0_a;
      op_q.b  <= (grant_id == REQ1) ? req1_b : req0_b;
      op_q.id <= grant_id;
    end
  end

  // Remember the last winner; starts at 1 so requester 0 takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= REQ1;
    else if (accept) last_q <= grant_id;
  end

  fpadd_core u_core (
    .a   (op_q.a),
    .b   (op_q.b),
    .sum (core_sum)
  );

  // Register the adder result during EXEC; it then holds through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      id_q  <= REQ0;
    end else if (state_q == EXEC) begin
      sum_q <= core_sum;
      id_q  <= op_q.id;
    end
  end

  // Count completed response handshakes, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (rsp_valid && rsp_ready) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign rsp_sum  = sum_q;
  assign rsp_id   = id_q;
  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_fpadd_sched.sv
// tb/tb_fpadd_sched.sv - directed self-checking bench for fpadd_sched
module tb_fpadd_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_sum;
  logic [15:0] done_cnt;

  logic        fp0_valid, fp1_valid, fp0_ready, fp1_ready;
  logic [31:0] fp0_a, fp0_b, fp1_a, fp1_b;
  logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_busy;
  logic [31:0] fp_rsp_sum;
  logic [15:0] fp_done_cnt;

  int          checks;
  int          errors;
  logic [15:0] exp_cnt;

  fpadd_sched #(.RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .done_cnt(done_cnt)
  );

  fpadd_sched #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fp0_valid), .req0_a(fp0_a), .req0_b(fp0_b), .req0_ready(fp0_ready),
    .req1_valid(fp1_valid), .req1_a(fp1_a), .req1_b(fp1_b), .req1_ready(fp1_ready),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id), .rsp_sum(fp_rsp_sum),
    .busy(fp_busy), .done_cnt(fp_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_sum, input string tag);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    chkb({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chkb({tag, "_exec_valid"}, rsp_valid, 1'b0);
    tick();
    #1;
    chkb({tag, "_valid"}, rsp_valid, 1'b1);
    chkb({tag, "_id"}, rsp_id, id);
    chk({tag, "_sum"}, rsp_sum, exp_sum);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    #1;
    chk({tag, "_cnt"}, 32'(done_cnt), 32'(exp_cnt));
    chkb({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 16'd0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    req1_valid = 1'b0; req1_a = 32'h0; req1_b = 32'h0;
    fp0_valid = 1'b0; fp0_a = 32'h0; fp0_b = 32'h0;
    fp1_valid = 1'b0; fp1_a = 32'h0; fp1_b = 32'h0;
    fp_rsp_ready = 1'b0;

    // Reset values, with a request already pending
    repeat (2) @(negedge clk);
    #1;
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chkb("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_sum", rsp_sum, 32'h0);
    chk("rst_done_cnt", 32'(done_cnt), 32'h0);
    chkb("rst_req0_ready", req0_ready, 1'b0);
    chkb("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_fp_done_cnt", 32'(fp_done_cnt), 32'h0);

    // Single request 1.0 + 2.0, accepted on the first edge after reset release
    rst_n = 1'b1;
    #1;
    chkb("t1_req0_ready", req0_ready, 1'b1);
    chkb("t1_req1_ready", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    #1;
    chkb("t1_exec_busy", busy, 1'b1);
    chkb("t1_exec_valid", rsp_valid, 1'b0);
    tick();
    #1;
    chkb("t1_valid", rsp_valid, 1'b1);
    chkb("t1_id", rsp_id, 1'b0);
    chk("t1_sum", rsp_sum, 32'h40400000);
    chk("t1_cnt_before", 32'(done_cnt), 32'h0);
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("t1_cnt", 32'(done_cnt), 32'h1);
    chkb("t1_idle", busy, 1'b0);

    // Backpressure on a tie-rounds-up result while requester 0 waits
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h3F800001; req1_b = 32'h33800000;
    #1;
    chkb("t2_req1_ready", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h33800000;
    #1;
    chkb("t2_exec_req0_ready", req0_ready, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chkb("t2_bp_valid", rsp_valid, 1'b1);
      chk("t2_bp_sum", rsp_sum, 32'h3F800002);
      chkb("t2_bp_id", rsp_id, 1'b1);
      chkb("t2_bp_req0_ready", req0_ready, 1'b0);
      chkb("t2_bp_req1_ready", req1_ready, 1'b0);
      chk("t2_bp_cnt", 32'(done_cnt), 32'h1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("t2_cnt", 32'(done_cnt), 32'h2);
    chkb("t2_waiting_req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    chkb("t2_tie_id", rsp_id, 1'b0);
    chk("t2_tie_even_sum", rsp_sum, 32'h3F800000);
    tick();
    #1;
    chk("t2_cnt2", 32'(done_cnt), 32'h3);

    // Round-robin from reset with both requesters continuously valid
    rst_n = 1'b0;
    #1;
    chk("t3_rst_cnt", 32'(done_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1; req1_a = 32'h40A00000; req1_b = 32'hC0400000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chkb("t3_req0_ready", req0_ready, (k % 2) == 0);
      chkb("t3_req1_ready", req1_ready, (k % 2) == 1);
      tick();
      #1;
      chkb("t3_exec_busy", busy, 1'b1);
      tick();
      #1;
      chkb("t3_valid", rsp_valid, 1'b1);
      chkb("t3_id", rsp_id, k[0]);
      chk("t3_sum", rsp_sum, 32'h40000000);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("t3_cnt", 32'(done_cnt), 32'h4);

    // Reset one cycle after accept discards the operation
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'hBF800000;
    #1;
    chkb("t4_req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chkb("t4_rst_busy", busy, 1'b0);
    chkb("t4_rst_valid", rsp_valid, 1'b0);
    chk("t4_rst_cnt", 32'(done_cnt), 32'h0);
    chk("t4_rst_sum", rsp_sum, 32'h0);
    tick();
    #1;
    chkb("t4_rst_valid2", rsp_valid, 1'b0);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    do_op(1'b1, 32'h00000001, 32'h00000001, 32'h00000002, "t4_denorm");
    do_op(1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, "t4_round_up");
    do_op(1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, "t4_cancel");

    // Counter wrap from 0xFFFF
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("t5_preset_cnt", 32'(done_cnt), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    do_op(1'b1, 32'h40A00000, 32'hC0400000, 32'h40000000, "t5_wrap");
    chk("t5_wrapped", 32'(done_cnt), 32'h0);

    // Fixed priority: requester 1 starves while requester 0 stays valid
    fp_rsp_ready = 1'b1;
    fp0_valid = 1'b1; fp0_a = 32'h3F800000; fp0_b = 32'h40000000;
    fp1_valid = 1'b1; fp1_a = 32'h40A00000; fp1_b = 32'hC0400000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chkb("t6_fp0_ready", fp0_ready, 1'b1);
      chkb("t6_fp1_ready", fp1_ready, 1'b0);
      tick();
      #1;
      chkb("t6_exec_fp1_ready", fp1_ready, 1'b0);
      tick();
      #1;
      chkb("t6_valid", fp_rsp_valid, 1'b1);
      chkb("t6_id", fp_rsp_id, 1'b0);
      chk("t6_sum", fp_rsp_sum, 32'h40400000);
      chkb("t6_done_fp1_ready", fp1_ready, 1'b0);
      tick();
    end
    fp0_valid = 1'b0;
    fp1_valid = 1'b0;
    #1;
    chk("t6_cnt", 32'(fp_done_cnt), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
